// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one interval counter among N_REQ requesters.
// Each winner gets len+1 COUNT cycles, then a one-cycle done pulse.
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [N_REQ-1:0]       req_in,
    input  logic [N_REQ*CNT_W-1:0] len_in,
    output logic [N_REQ-1:0]       gnt_out,
    output logic [N_REQ-1:0]       done_out,
    output logic                   busy_out,
    output logic [CNT_W-1:0]       data_out,
    output logic                   tc_out
);
    localparam int PW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t           r_state, w_state;
    logic [PW-1:0]    r_ptr, w_ptr, r_win, w_win, w_pick, w_inc;
    logic [CNT_W-1:0] r_len, w_len, w_pick_len, w_data;
    logic [N_REQ-1:0] w_gnt, w_done;
    logic             w_busy, w_tc;
    // Requesters at or above the pointer override those below it; lowest index wins within each group.
    always_comb begin
        w_pick = r_ptr;
        w_pick_len = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_in[i] && i < int'(r_ptr)) w_pick = PW'(i);
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_in[i] && i >= int'(r_ptr)) w_pick = PW'(i);
        for (int i = 0; i < N_REQ; i++)
            if (PW'(i) == w_pick) w_pick_len = len_in[i*CNT_W +: CNT_W];
    end
    assign w_inc = (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
    always_comb begin
        w_state = r_state;
        w_ptr = r_ptr;
        w_win = r_win;
        w_len = r_len;
        w_gnt = '0;
        w_done = '0;
        w_busy = 1'b0;
        w_data = '0;
        w_tc = 1'b0;
        case (r_state)
            IDLE: if (|req_in) begin
                w_state = COUNT;
                w_win = w_pick;
                w_len = w_pick_len;
                w_gnt = N_REQ'(1) << w_pick;
                w_busy = 1'b1;
                w_tc = (w_pick_len == '0);
            end
            COUNT: if (!req_in[r_win]) begin
                w_state = IDLE;
                w_ptr = w_inc;
            end else if (tc_out) begin
                w_state = DONE;
                w_ptr = w_inc;
                w_done = N_REQ'(1) << r_win;
                w_busy = 1'b1;
            end else begin
                w_gnt = gnt_out;
                w_busy = 1'b1;
                w_data = data_out + 1'b1;
                w_tc = ((data_out + 1'b1) == r_len);
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_ptr <= '0;
            r_win <= '0;
            r_len <= '0;
            gnt_out <= '0;
            done_out <= '0;
            busy_out <= 1'b0;
            data_out <= '0;
            tc_out <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr <= w_ptr;
            r_win <= w_win;
            r_len <= w_len;
            gnt_out <= w_gnt;
            done_out <= w_done;
            busy_out <= w_busy;
            data_out <= w_data;
            tc_out <= w_tc;
        end
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: vector-table bench with per-cycle invariant checks for timer_arbiter
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  logic clk_in = 1'b0;
  logic rst_in;
  logic [N-1:0] req_in, gnt_out, done_out;
  logic [N*W-1:0] len_in;
  logic busy_out, tc_out;
  logic [W-1:0] data_out;
  typedef struct {
    string tag;
    logic rst;
    logic [N-1:0] req;
    logic [N*W-1:0] len;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic busy;
    logic [W-1:0] data;
    logic tc;
  } vec_t;
  typedef logic [2*N+W+1:0] obs_t;
  vec_t vecs[$];
  obs_t exp_q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk_in = ~clk_in;
  timer_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .len_in(len_in),
    .gnt_out(gnt_out), .done_out(done_out), .busy_out(busy_out),
    .data_out(data_out), .tc_out(tc_out)
  );
  function automatic void add(string tag, logic rst, logic [N-1:0] req, logic [N*W-1:0] len,
                              logic [N-1:0] gnt, logic [N-1:0] done, logic busy,
                              logic [W-1:0] data, logic tc);
    vec_t v;
    v.tag = tag; v.rst = rst; v.req = req; v.len = len;
    v.gnt = gnt; v.done = done; v.busy = busy; v.data = data; v.tc = tc;
    vecs.push_back(v);
  endfunction
  function automatic void add_job(string tag, logic [N-1:0] req, logic [N*W-1:0] len,
                                  int w, int l, logic [N-1:0] req_after);
    logic [N-1:0] oh;
    oh = N'(1) << w;
    for (int c = 0; c <= l; c++) add(tag, 1'b0, req, len, oh, '0, 1'b1, W'(c), c == l);
    add({tag, "_done"}, 1'b0, req, len, '0, oh, 1'b1, '0, 1'b0);
    add({tag, "_idle"}, 1'b0, req_after, len, '0, '0, 1'b0, '0, 1'b0);
  endfunction
  initial begin
    obs_t got, exp;
    logic inv_ok;
    rst_in = 1'b1;
    req_in = '0;
    len_in = '0;
    add("reset", 1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0);
    add("single", 0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 0, 0);
    add("single", 0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 1, 0);
    add("single", 0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 2, 0);
    add("single", 0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 3, 1);
    add("single_done", 0, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 1, 0, 0);
    add("single_idle", 0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 0, 0, 0);
    add("single_idle2", 0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 0, 0, 0);
    add_job("len0", 4'b0001, 16'h0000, 0, 0, 4'b0000);
    add_job("len15", 4'b0001, 16'h000F, 0, 15, 4'b0000);
    add("rr_reset", 1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0);
    add_job("rr0", 4'b1111, 16'h3012, 0, 2, 4'b1111);
    add_job("rr1", 4'b1111, 16'h3012, 1, 1, 4'b1111);
    add_job("rr2", 4'b1111, 16'h3012, 2, 0, 4'b1111);
    add_job("rr3", 4'b1111, 16'h3012, 3, 3, 4'b1111);
    add_job("rr0b", 4'b1111, 16'h3012, 0, 2, 4'b0000);
    add("abort", 0, 4'b0100, 16'h0600, 4'b0100, 4'b0000, 1, 0, 0);
    add("abort", 0, 4'b0100, 16'h0600, 4'b0100, 4'b0000, 1, 1, 0);
    add("abort", 0, 4'b0100, 16'h0600, 4'b0100, 4'b0000, 1, 2, 0);
    add("abort_drop", 0, 4'b0000, 16'h0600, 4'b0000, 4'b0000, 0, 0, 0);
    add_job("abort_next", 4'b1101, 16'h0600, 3, 0, 4'b0000);
    add("latch", 0, 4'b0001, 16'h0004, 4'b0001, 4'b0000, 1, 0, 0);
    add("latch", 0, 4'b0011, 16'h0001, 4'b0001, 4'b0000, 1, 1, 0);
    add("latch", 0, 4'b0011, 16'h0001, 4'b0001, 4'b0000, 1, 2, 0);
    add("latch", 0, 4'b0011, 16'h0001, 4'b0001, 4'b0000, 1, 3, 0);
    add("latch", 0, 4'b0011, 16'h0001, 4'b0001, 4'b0000, 1, 4, 1);
    add("latch_done", 0, 4'b0011, 16'h0001, 4'b0000, 4'b0001, 1, 0, 0);
    add("latch_idle", 0, 4'b0010, 16'h0001, 4'b0000, 4'b0000, 0, 0, 0);
    add_job("latch_pend", 4'b0010, 16'h0001, 1, 0, 4'b0000);
    add("rstmid", 0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 0, 0);
    add("rstmid", 0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 1, 0);
    add("rstmid", 0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 2, 0);
    add("rstmid", 0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 3, 0);
    add("rstmid_rst", 1, 4'b0101, 16'h0005, 4'b0000, 4'b0000, 0, 0, 0);
    add("rstmid_ptr", 0, 4'b0101, 16'h0005, 4'b0001, 4'b0000, 1, 0, 0);
    add("rstmid_end", 1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0);
    foreach (vecs[k]) begin
      @(negedge clk_in);
      rst_in = vecs[k].rst;
      req_in = vecs[k].req;
      len_in = vecs[k].len;
      exp_q.push_back({vecs[k].gnt, vecs[k].done, vecs[k].busy, vecs[k].data, vecs[k].tc});
      @(posedge clk_in);
      #1;
      got = {gnt_out, done_out, busy_out, data_out, tc_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s[%0d] got gnt=%b done=%b busy=%b data=%0d tc=%b, want gnt=%b done=%b busy=%b data=%0d tc=%b",
                 vecs[k].tag, k, gnt_out, done_out, busy_out, data_out, tc_out,
                 vecs[k].gnt, vecs[k].done, vecs[k].busy, vecs[k].data, vecs[k].tc);
      end
      inv_ok = $onehot0(gnt_out) && $onehot0(done_out) && ((gnt_out & done_out) == '0)
               && (!tc_out || (gnt_out != '0));
      checks++;
      if (inv_ok !== 1'b1) begin
        errors++;
        $display("FAIL invariant %s[%0d] gnt=%b done=%b tc=%b", vecs[k].tag, k, gnt_out, done_out, tc_out);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
Shares a single free-running-style up-counter (frcounter datapath, CNT_W bits) between N_REQ requesters, each of which needs a timed interval of programmable length.
- Arbitrates pending requests round-robin and loads the winner's length.
- Sequences the count and flags terminal count.
- Returns a one-cycle done pulse to the winner.
- Sits between requesting control blocks and the counter resource.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 4, counter width in bits; max interval length 2^CNT_W-1

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_in  input  1  synchronous reset, active-high
req_in  input  N_REQ  per-requester request level; held high until done_out or voluntarily dropped (abort)
len_in  input  N_REQ*CNT_W  per-requester terminal value; slice i = len_in[i*CNT_W +: CNT_W]
gnt_out  output  N_REQ  one-hot grant, high for the whole COUNT phase of the winner
done_out  output  N_REQ  one-hot, one-cycle pulse to the winner after terminal count
busy_out  output  1  high in COUNT and DONE
data_out  output  CNT_W  current count value of the shared counter
tc_out  output  1  high in the COUNT cycle where data_out == latched length

Behaviour:
- All outputs registered. Reset (rst_in=1 at a clock edge):
  - state=IDLE; gnt_out, done_out, data_out, tc_out, busy_out = 0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - Reset overrides everything, including mid-count; no done pulse is issued.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If any req_in bit is high, pick the first set bit scanning from pointer upward with wrap.
  - Latch len_in slice of the winner into len_q.
  - Next cycle: state=COUNT, gnt_out=onehot(winner), data_out=0, busy_out=1.
  - If no request, stay IDLE with all outputs 0.
- COUNT:
  - data_out increments by 1 each cycle, starting at 0.
  - tc_out=1 exactly in the cycle data_out==len_q. The next cycle goes to DONE.
  - COUNT lasts len_q+1 cycles. len_q=0 gives 1 COUNT cycle with data_out=0 and tc_out=1.
  - len_q=2^CNT_W-1 counts through the full range with no wrap.
  - len_in changes after latch are ignored.
  - Abort: if req_in[winner] is 0 in any COUNT cycle (sampled at the edge), the next state is IDLE:
    - gnt_out, data_out, tc_out, busy_out go to 0.
    - No done pulse is issued; the pointer still advances to winner+1.
  - Requests from other requesters are ignored during COUNT; they stay pending.
- DONE (one cycle):
  - done_out=onehot(winner), gnt_out=0, data_out=0, tc_out=0, busy_out=1.
  - Pointer = (winner+1) mod N_REQ. Next state is IDLE.
- Arbitration happens only in IDLE. Back-to-back jobs therefore have one IDLE cycle between DONE and the next COUNT.
- Simultaneous requests: the lowest index at or above the pointer wins; the others wait. No requester is starved: worst-case wait is (N_REQ-1) jobs.
- A requester whose req_in is still high in the IDLE cycle after its own DONE is treated as a new request, subject to the pointer.
- Invariants:
  - gnt_out and done_out are each one-hot or zero and never high together.
  - tc_out implies some gnt_out bit is high.

Test Plan:
- Reset mid-count: req_in=0001, len=5, assert rst_in when data_out=3 -> next cycle all outputs 0, no done_out, and the next grant goes to requester 0 (pointer reset).
- Single job: req_in=0001, len0=3 -> gnt_out=0001 for 4 cycles with data_out 0,1,2,3; tc_out high only at 3; then done_out=0001 for exactly 1 cycle; then IDLE.
- Edge lengths: len0=0 -> 1 COUNT cycle with data_out=0, tc_out=1. len0=15 -> 16 COUNT cycles, data_out 0..15 with no wrap, tc_out at 15.
- Round-robin: req_in=1111 held, lengths 2,1,0,3 -> grant order 0,1,2,3,0; each done_out in the cycle after its tc_out; one IDLE cycle between jobs.
- Abort: req_in=0100, len2=6, drop req_in[2] when data_out=2 -> IDLE next cycle, no done_out[2], next winner search starts at requester 3.
- Latch check: change len_in slice of the active winner from 4 to 1 during COUNT -> tc_out still at data_out=4; pending req_in=0010 during the job is granted only after DONE+IDLE.
